// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver: one digit per SCAN_DIV clocks, shadowed value, leading-zero blanking.
// Outputs fully registered (1-cycle latency); no backpressure, load is always accepted.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] TERM     = PW'(SCAN_DIV - 1);
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // Active-low pattern, bit order g..a
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   blank_nxt;
  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic                    wrap_q;
  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_hex;
  logic [6:0]              seg_al;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   an_sel;

  // A digit blanks only if it and every more significant digit are zero; digit 0 always shows.
  always_comb begin : blank_calc
    logic all_zero;
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero     = all_zero & (value[4*k +: 4] == 4'h0);
      blank_nxt[k] = lz_en & all_zero;
    end
  end

  assign tick = enable && (presc == TERM);
  assign wrap = tick && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      presc    <= '0;
      idx      <= '0;
      wrap_q   <= 1'b0;
    end else begin
      if (load) begin
        sh_val   <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank_nxt;
      end
      if (tick) begin
        presc <= '0;
        idx   <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end else if (enable) begin
        presc <= presc + PW'(1);
      end
      wrap_q <= wrap;
    end
  end

  always_comb begin
    cur_hex = 4'(sh_val >> {idx, 2'b00});
    seg_al  = sh_blank[idx] ? 7'b1111111 : hex7(cur_hex);
    dp_lit  = sh_dp[idx];
    an_sel  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_sel[i] = (idx == IW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else if (enable) begin
      seg        <= SEG_ACTIVE_LOW ? seg_al : ~seg_al;
      dp         <= SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
      an         <= AN_ACTIVE_LOW ? ~an_sel : an_sel;
      frame_done <= wrap_q;
    end else begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected per-cycle display state is queued by the
// stimulus; a negedge monitor pops and compares whenever a digit is being driven.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset, enable, load, lz_en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp, frame_done;
  logic [3:0]  an;

  logic        reset2, enable2, load2;
  logic [15:0] value2;
  logic [6:0]  seg2;
  logic        dp2, frame_done2;
  logic [3:0]  an2;

  int vectors = 0;
  int miscompares = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .lz_en(lz_en), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .enable(enable2), .load(load2), .value(value2), .dp_in(4'b0000),
    .lz_en(1'b0), .seg(seg2), .dp(dp2), .an(an2), .frame_done(frame_done2));

  task automatic chk(input string name, input exp_t got, input exp_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
               name, got.an, got.seg, got.dp, got.fd, want.an, want.seg, want.dp, want.fd);
    end
  endtask

  task automatic push(input bit which, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input logic fd_first, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) q2.push_back('{a, s, d, (i == 0) ? fd_first : 1'b0});
      else       q1.push_back('{a, s, d, (i == 0) ? fd_first : 1'b0});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_chk(input string name, input int left);
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected outputs never appeared, expected 0 left", name, left);
    end
  endtask

  always @(negedge clk) begin
    if (an !== 4'b1111) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut_unexpected: got an=%b seg=%b, expected dark", an, seg);
      end else begin
        chk("dut_scan", '{an, seg, dp, frame_done}, q1.pop_front());
      end
    end
    if (an2 !== 4'b0000) begin
      if (q2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut2_unexpected: got an=%b seg=%b, expected dark", an2, seg2);
      end else begin
        chk("dut2_scan", '{an2, seg2, dp2, frame_done2}, q2.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; lz_en = 1'b0; value = '0; dp_in = '0;
    reset2 = 1'b1; enable2 = 1'b0; load2 = 1'b0; value2 = '0;
    #2;
    chk("reset_state", '{an, seg, dp, frame_done}, '{4'b1111, SB, 1'b1, 1'b0});
    chk("reset_state_pol0", '{an2, seg2, dp2, frame_done2}, '{4'b0000, 7'b0000000, 1'b0, 1'b0});

    // Scan zeros briefly, then reset mid-digit-1
    step(1);
    reset = 1'b0; enable = 1'b1;
    push(0, 4'b1110, S0, 1'b1, 1'b0, 4);
    push(0, 4'b1101, S0, 1'b1, 1'b0, 2);
    step(6);
    #6;
    reset = 1'b1;
    #1;
    chk("reset_mid_scan", '{an, seg, dp, frame_done}, '{4'b1111, SB, 1'b1, 1'b0});

    // Release with a load of 12AF; first digit still shows the old shadow value
    step(1);
    reset = 1'b0; load = 1'b1; value = 16'h12AF; dp_in = 4'b0100; lz_en = 1'b0;
    push(0, 4'b1110, S0, 1'b1, 1'b0, 1);
    push(0, 4'b1110, SF, 1'b1, 1'b0, 3);
    push(0, 4'b1101, SA, 1'b1, 1'b0, 4);
    push(0, 4'b1011, S2, 1'b0, 1'b0, 4);
    push(0, 4'b0111, S1, 1'b1, 1'b0, 4);
    push(0, 4'b1110, SF, 1'b1, 1'b1, 4);
    push(0, 4'b1101, SA, 1'b1, 1'b0, 4);
    push(0, 4'b1011, S2, 1'b0, 1'b0, 4);
    push(0, 4'b0111, S1, 1'b1, 1'b0, 4);
    step(1);
    load = 1'b0;

    // Load 0030 with blanking on the same edge as the wrap
    step(30);
    load = 1'b1; value = 16'h0030; dp_in = 4'b0000; lz_en = 1'b1;
    push(0, 4'b1110, S0, 1'b1, 1'b1, 4);
    push(0, 4'b1101, S3, 1'b1, 1'b0, 4);
    push(0, 4'b1011, SB, 1'b1, 1'b0, 4);
    push(0, 4'b0111, SB, 1'b1, 1'b0, 4);
    step(1);
    load = 1'b0;

    // All-zero value with blanking; blanked digit 3 keeps its dp
    step(15);
    load = 1'b1; value = 16'h0000; dp_in = 4'b1000; lz_en = 1'b1;
    push(0, 4'b1110, S0, 1'b1, 1'b1, 4);
    push(0, 4'b1101, SB, 1'b1, 1'b0, 4);
    push(0, 4'b1011, SB, 1'b1, 1'b0, 1);
    step(1);
    load = 1'b0;

    // Drop enable in cycle 1 of digit 2, resume 10 cycles later
    step(9);
    enable = 1'b0;
    step(4);
    chk("disabled_dark", '{an, seg, dp, frame_done}, '{4'b1111, SB, 1'b1, 1'b0});
    step(6);
    enable = 1'b1;
    push(0, 4'b1011, SB, 1'b1, 1'b0, 3);
    push(0, 4'b0111, SB, 1'b0, 1'b0, 4);
    push(0, 4'b1110, S0, 1'b1, 1'b1, 4);
    step(11);
    enable = 1'b0;
    step(3);
    drain_chk("dut_drain", q1.size());

    // Active-high polarity instance showing digit 8
    step(1);
    reset2 = 1'b0; enable2 = 1'b1; load2 = 1'b1; value2 = 16'h0008;
    push(1, 4'b0001, ~S0, 1'b0, 1'b0, 1);
    push(1, 4'b0001, 7'b1111111, 1'b0, 1'b0, 3);
    push(1, 4'b0010, ~S0, 1'b0, 1'b0, 1);
    step(1);
    load2 = 1'b0;
    step(4);
    enable2 = 1'b0;
    step(3);
    drain_chk("dut2_drain", q2.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
